// File: rtl/bsg_tag_trace_sender.sv
// Serialises bsg_tag packets and master-reset bursts onto a tag master data/enable pair.
// Optional packet counter output pkts_sent_o is enabled by defining BSG_TAG_TRACE_SENDER_COUNT_EN.
module bsg_tag_trace_sender #(
  parameter int els_p               = 4,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 9,
  parameter int reset_len_p         = 16,
  parameter int gap_p               = 2,
  localparam int lg_els             = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [lg_els-1:0]              node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  input  logic                           master_reset_i,
  output logic                           tag_data_o,
  output logic                           tag_en_o,
  output logic                           err_o
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
  , output logic [15:0]                  pkts_sent_o
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int cnt_max_lp = max2(max2(max2(lg_els, lg_width_p), max2(max_payload_width_p, reset_len_p)), gap_p);
  localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);

  typedef enum logic [2:0] {IDLE, MRST, START, ID, DNR, LEN, PAYLOAD, GAP} state_e;

  state_e                         state_r, state_n;
  logic [cnt_w_lp-1:0]            cnt_r, cnt_n;
  logic [lg_els-1:0]              node_r;
  logic                           dnr_r;
  logic [lg_width_p-1:0]          len_r;
  logic [max_payload_width_p-1:0] payload_r;
  logic                           err_r;
  logic                           data_n;
  logic                           accept;
  logic                           done;
  logic                           len_over;
  logic [lg_width_p-1:0]          len_clamped;

  assign ready_o = (state_r == IDLE);
  assign err_o   = err_r;

  // Lengths beyond the payload register are clamped so the length field matches the bits actually sent
  assign len_over    = int'(len_i) > max_payload_width_p;
  assign len_clamped = len_over ? lg_width_p'(max_payload_width_p) : len_i;

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + 1'b1;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_r)
      IDLE: begin
        cnt_n = '0;
        if (master_reset_i) state_n = MRST;
        else if (v_i) begin
          state_n = START;
          accept  = 1'b1;
        end
      end
      MRST: if (cnt_r == cnt_w_lp'(reset_len_p - 1)) begin
        state_n = GAP;
        cnt_n   = '0;
      end
      START: begin
        state_n = ID;
        cnt_n   = '0;
      end
      ID: if (cnt_r == cnt_w_lp'(lg_els - 1)) begin
        state_n = DNR;
        cnt_n   = '0;
      end
      DNR: begin
        state_n = LEN;
        cnt_n   = '0;
      end
      LEN: if (cnt_r == cnt_w_lp'(lg_width_p - 1)) begin
        state_n = (len_r == '0) ? GAP : PAYLOAD;
        cnt_n   = '0;
      end
      PAYLOAD: if (cnt_r == cnt_w_lp'(len_r) - 1'b1) begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: if (cnt_r == cnt_w_lp'(gap_p - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
        done    = 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // The output register carries the bit belonging to the state being entered
    unique case (state_n)
      MRST, START: data_n = 1'b1;
      ID:          data_n = 1'(node_r >> cnt_n);
      DNR:         data_n = dnr_r;
      LEN:         data_n = 1'(len_r >> cnt_n);
      PAYLOAD:     data_n = 1'(payload_r >> cnt_n);
      default:     data_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      tag_data_o <= data_n;
      tag_en_o   <= (state_n != IDLE);
      if (accept && len_over) err_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      node_r    <= node_id_i;
      dnr_r     <= data_not_reset_i;
      len_r     <= len_clamped;
      payload_r <= payload_i;
    end
  end

`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)   pkts_sent_o <= '0;
    else if (done) pkts_sent_o <= pkts_sent_o + 16'd1;
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_bsg_tag_trace_sender.sv
// Self-checking bench for bsg_tag_trace_sender: directed scenarios plus randomized packets vs. a bit-list model.
module tb_bsg_tag_trace_sender;
  localparam int ELS = 4, LGW = 4, MAXP = 9, RLEN = 16, GAP = 2, LGE = 2;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            v_i = 1'b0;
  logic            ready_o;
  logic [LGE-1:0]  node_id_i = '0;
  logic            data_not_reset_i = 1'b0;
  logic [LGW-1:0]  len_i = '0;
  logic [MAXP-1:0] payload_i = '0;
  logic            master_reset_i = 1'b0;
  logic            tag_data_o, tag_en_o, err_o;
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
  logic [15:0]     pkts_sent_o;
`endif

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;
  int pkts_exp = 0;

  bsg_tag_trace_sender #(.els_p(ELS), .lg_width_p(LGW), .max_payload_width_p(MAXP),
                         .reset_len_p(RLEN), .gap_p(GAP)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .node_id_i(node_id_i),
    .data_not_reset_i(data_not_reset_i), .len_i(len_i), .payload_i(payload_i),
    .master_reset_i(master_reset_i), .tag_data_o(tag_data_o), .tag_en_o(tag_en_o), .err_o(err_o)
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
    , .pkts_sent_o(pkts_sent_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the ordered list of serial bits for a request, built from the packet format rules.
  function automatic void model(input int node, input int dnr, input int len, input int payload,
                                input bit mrst, output logic [63:0] bits, output int n);
    int l;
    bits = '0;
    n = 0;
    if (mrst) begin
      for (int i = 0; i < RLEN; i++) begin bits[n] = 1'b1; n++; end
    end else begin
      l = (len > MAXP) ? MAXP : len;
      bits[n] = 1'b1; n++;
      for (int i = 0; i < LGE; i++) begin bits[n] = 1'((node >> i) & 1); n++; end
      bits[n] = 1'(dnr); n++;
      for (int i = 0; i < LGW; i++) begin bits[n] = 1'((l >> i) & 1); n++; end
      for (int i = 0; i < l; i++) begin bits[n] = 1'((payload >> i) & 1); n++; end
    end
    n = n + GAP;
  endfunction

  task automatic issue(input int node, input int dnr, input int len, input int payload,
                       input bit mrst, input bit v);
    @(negedge clk);
    node_id_i = LGE'(node);
    data_not_reset_i = 1'(dnr);
    len_i = LGW'(len);
    payload_i = MAXP'(payload);
    master_reset_i = mrst;
    v_i = v;
    @(posedge clk);
    #1;
    v_i = 1'b0;
    master_reset_i = 1'b0;
  endtask

  task automatic collect(input int n, input bit toggle, output logic [63:0] obs, output bit en_ok,
                         output bit rdy_busy, output logic rdy_after, output logic en_after);
    obs = '0;
    en_ok = 1'b1;
    rdy_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs[i] = tag_data_o;
      if (tag_en_o !== 1'b1) en_ok = 1'b0;
      if (ready_o !== 1'b0) rdy_busy = 1'b1;
      if (toggle) begin
        v_i = 1'($urandom);
        master_reset_i = 1'($urandom);
        node_id_i = LGE'($urandom);
        len_i = LGW'($urandom);
        payload_i = MAXP'($urandom);
      end
    end
    @(negedge clk);
    rdy_after = ready_o;
    en_after = tag_en_o;
    v_i = 1'b0;
    master_reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    err_exp = 1'b0;
    pkts_exp = 0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if (tag_en_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", tag_en_o); end
    checks++; if (tag_data_o !== 1'b0) begin errors++; $display("FAIL reset_data got %b exp 0", tag_data_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
    checks++; if (pkts_sent_o !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pkts_sent_o); end
`endif
  endtask

  task automatic test_basic();
    logic [63:0] obs; bit en_ok, rb; logic ra, ea;
    issue(2, 1, 3, 'b101, 1'b0, 1'b1);
    collect(13, 1'b0, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    checks++; if (obs !== 64'h053D) begin errors++; $display("FAIL basic_stream got %h exp %h", obs, 64'h053D); end
    checks++; if (!en_ok || rb) begin errors++; $display("FAIL basic_busy en_ok %b ready_seen %b exp 1 0", en_ok, rb); end
    checks++; if (ra !== 1'b1 || ea !== 1'b0) begin errors++; $display("FAIL basic_end ready %b en %b exp 1 0", ra, ea); end
  endtask

  task automatic test_mrst_priority();
    logic [63:0] obs; bit en_ok, rb; logic ra, ea;
    issue(3, 1, 5, 'h1F, 1'b1, 1'b1);
    collect(18, 1'b0, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    checks++; if (obs !== 64'h0FFFF) begin errors++; $display("FAIL mrst_stream got %h exp %h", obs, 64'h0FFFF); end
    checks++; if (!en_ok || rb) begin errors++; $display("FAIL mrst_busy en_ok %b ready_seen %b exp 1 0", en_ok, rb); end
    checks++; if (ra !== 1'b1 || ea !== 1'b0) begin errors++; $display("FAIL mrst_end ready %b en %b exp 1 0", ra, ea); end
    @(negedge clk);
    checks++; if (tag_en_o !== 1'b0) begin errors++; $display("FAIL mrst_no_packet en %b exp 0", tag_en_o); end
  endtask

  task automatic test_len0();
    logic [63:0] obs; bit en_ok, rb; logic ra, ea;
    issue(1, 0, 0, 'h1AB, 1'b0, 1'b1);
    collect(10, 1'b0, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    checks++; if (obs !== 64'h3) begin errors++; $display("FAIL len0_stream got %h exp %h", obs, 64'h3); end
    checks++; if (!en_ok || rb || ra !== 1'b1) begin errors++; $display("FAIL len0_timing en_ok %b ready_seen %b ready_end %b exp 1 0 1", en_ok, rb, ra); end
  endtask

  task automatic test_clamp();
    logic [63:0] obs, exp_bits; int n; bit en_ok, rb; logic ra, ea;
    model(3, 1, 12, 'h1FF, 1'b0, exp_bits, n);
    issue(3, 1, 12, 'h1FF, 1'b0, 1'b1);
    collect(n, 1'b0, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    err_exp = 1'b1;
    checks++; if (n != 19 || obs !== exp_bits) begin errors++; $display("FAIL clamp_stream got %h exp %h n %0d", obs, exp_bits, n); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clamp_err got %b exp 1", err_o); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL clamp_end ready %b exp 1", ra); end
    issue(0, 1, 2, 'h2, 1'b0, 1'b1);
    collect(12, 1'b0, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clamp_err_sticky got %b exp 1", err_o); end
  endtask

  task automatic test_abort();
    bit en_zero = 1'b1;
    issue(2, 1, 7, 'h55, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    err_exp = 1'b0;
`ifndef BSG_TAG_TRACE_SENDER_COUNT_EN
    pkts_exp = 0;
`endif
    @(negedge clk);
    checks++; if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0 || ready_o !== 1'b1)
      begin errors++; $display("FAIL abort_state en %b data %b ready %b exp 0 0 1", tag_en_o, tag_data_o, ready_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL abort_err got %b exp 0", err_o); end
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
    checks++; if (pkts_sent_o !== 16'd0) begin errors++; $display("FAIL abort_count got %0d exp 0", pkts_sent_o); end
    pkts_exp = 0;
`endif
    repeat (20) begin
      @(negedge clk);
      if (tag_en_o !== 1'b0) en_zero = 1'b0;
    end
    checks++; if (!en_zero) begin errors++; $display("FAIL abort_resumed en went high exp 0"); end
  endtask

  task automatic test_v_toggle();
    logic [63:0] obs, exp_bits; int n; bit en_ok, rb; logic ra, ea;
    model(1, 1, 6, 'h2D, 1'b0, exp_bits, n);
    issue(1, 1, 6, 'h2D, 1'b0, 1'b1);
    collect(n, 1'b1, obs, en_ok, rb, ra, ea);
    pkts_exp++;
    checks++; if (obs !== exp_bits) begin errors++; $display("FAIL toggle_stream got %h exp %h", obs, exp_bits); end
    checks++; if (!en_ok || rb || ra !== 1'b1) begin errors++; $display("FAIL toggle_timing en_ok %b ready_seen %b ready_end %b exp 1 0 1", en_ok, rb, ra); end
  endtask

  task automatic test_random();
    logic [63:0] obs, exp_bits; int n, node, dnr, len, pay; bit mrst, en_ok, rb; logic ra, ea;
    for (int k = 0; k < 30; k++) begin
      node = int'($urandom_range(0, ELS - 1));
      dnr  = int'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 15));
      pay  = int'($urandom_range(0, 511));
      mrst = ($urandom_range(0, 7) == 0);
      model(node, dnr, len, pay, mrst, exp_bits, n);
      issue(node, dnr, len, pay, mrst, 1'b1);
      collect(n, 1'b0, obs, en_ok, rb, ra, ea);
      pkts_exp++;
      if (!mrst && len > MAXP) err_exp = 1'b1;
      checks++; if (obs !== exp_bits) begin errors++; $display("FAIL rand_stream[%0d] got %h exp %h", k, obs, exp_bits); end
      checks++; if (!en_ok || rb || ra !== 1'b1 || ea !== 1'b0)
        begin errors++; $display("FAIL rand_timing[%0d] en_ok %b ready_seen %b ready_end %b en_end %b exp 1 0 1 0", k, en_ok, rb, ra, ea); end
      checks++; if (err_o !== err_exp) begin errors++; $display("FAIL rand_err[%0d] got %b exp %b", k, err_o, err_exp); end
    end
  endtask

  task automatic test_count();
`ifdef BSG_TAG_TRACE_SENDER_COUNT_EN
    checks++; if (pkts_sent_o !== 16'(pkts_exp)) begin errors++; $display("FAIL count got %0d exp %0d", pkts_sent_o, pkts_exp); end
`else
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL final_ready got %b exp 1", ready_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mrst_priority();
    test_len0();
    test_clamp();
    test_count();
    test_abort();
    test_v_toggle();
    test_random();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
